// File: rtl/dac_spi_driver.sv
// -----------------------------------------------------------------------------
// dac_spi_driver
// Serialises two 12-bit samples into a pair of 16-bit SPI frames for a
// dual-channel DAC (channel A, then channel B), then strobes LDAC so both
// channels update together.
//
// Ports
//   sys_clk_i      system clock, rising edge
//   sys_rst_i      asynchronous active-low reset
//   ds_en_i        transfer enable; starts are only taken while high
//   ds_start_i     one-cycle transfer request (sample-rate tick)
//   ds_sample_1_i  channel A sample, unsigned 12 bit
//   ds_sample_2_i  channel B sample, unsigned 12 bit
//   ds_cs_n_o      DAC chip select, active-low
//   ds_sck_o       SPI mode-0 serial clock
//   ds_sdi_o       serial data, MSB first
//   ds_ldac_n_o    DAC latch strobe, active-low
//   ds_busy_o      high while a transfer is in progress
//   ds_done_o      one-cycle pulse at end of transfer
//   ds_ovr_cnt_o   saturating count of starts dropped while busy
// -----------------------------------------------------------------------------
module dac_spi_driver #(
  parameter int         CLK_DIV  = 4,       // sys_clk cycles per SCK half-period, 1..255
  parameter logic [2:0] CFG_BITS = 3'b011   // {BUF, GA_n, SHDN_n}
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        ds_en_i,
  input  logic        ds_start_i,
  input  logic [11:0] ds_sample_1_i,
  input  logic [11:0] ds_sample_2_i,
  output logic        ds_cs_n_o,
  output logic        ds_sck_o,
  output logic        ds_sdi_o,
  output logic        ds_ldac_n_o,
  output logic        ds_busy_o,
  output logic        ds_done_o,
  output logic [7:0]  ds_ovr_cnt_o
);

  localparam logic [8:0] DIV_M1  = 9'(CLK_DIV - 1);
  localparam logic [8:0] LDAC_M1 = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT_A, GAP_A, SHIFT_B, GAP_B, LDAC, DONE
  } state_t;

  state_t      r_state;
  logic [8:0]  r_cnt;      // cycle counter within the current half-period / gap / strobe
  logic [4:0]  r_half;     // SCK half-period index within a frame, 0..31
  logic [15:0] r_shift;    // frame being shifted; MSB is the bit currently on SDI
  logic [11:0] r_samp2;    // channel B sample, held until frame B is loaded
  logic        r_cs_n;
  logic        r_sck;
  logic        r_sdi;
  logic        r_ldac_n;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_ovr;

  logic w_can_start;
  logic w_accept;
  logic w_drop;

  // DONE accepts a new start so back-to-back transfers only lose one cycle.
  assign w_can_start = (r_state == IDLE) || (r_state == DONE);
  assign w_accept    = ds_en_i && ds_start_i && w_can_start;
  assign w_drop      = ds_en_i && ds_start_i && !w_can_start;

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_half   <= '0;
      r_shift  <= '0;
      r_samp2  <= '0;
      r_cs_n   <= 1'b1;
      r_sck    <= 1'b0;
      r_sdi    <= 1'b0;
      r_ldac_n <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= '0;
    end else begin
      if (w_drop && (r_ovr != 8'hFF)) begin
        r_ovr <= r_ovr + 8'd1;
      end

      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            // Frame A doubles as the latch for sample 1.
            r_shift <= {1'b0, CFG_BITS, ds_sample_1_i};
            r_samp2 <= ds_sample_2_i;
            r_sdi   <= 1'b0;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_half  <= '0;
            r_state <= SHIFT_A;
          end else begin
            r_state <= IDLE;
          end
        end

        SHIFT_A, SHIFT_B: begin
          if (r_cnt == DIV_M1) begin
            r_cnt <= '0;
            if (r_half == 5'd31) begin
              // 16th falling edge: close the frame on this same cycle.
              r_cs_n  <= 1'b1;
              r_sck   <= 1'b0;
              r_sdi   <= 1'b0;
              r_state <= (r_state == SHIFT_A) ? GAP_A : GAP_B;
            end else begin
              r_half <= r_half + 5'd1;
              r_sck  <= ~r_sck;
              // Odd half ending means SCK is falling: present the next bit.
              if (r_half[0]) begin
                r_shift <= {r_shift[14:0], 1'b0};
                r_sdi   <= r_shift[14];
              end
            end
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        GAP_A: begin
          if (r_cnt == DIV_M1) begin
            r_cnt   <= '0;
            r_half  <= '0;
            r_shift <= {1'b1, CFG_BITS, r_samp2};
            r_sdi   <= 1'b1;
            r_cs_n  <= 1'b0;
            r_state <= SHIFT_B;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        GAP_B: begin
          if (r_cnt == DIV_M1) begin
            r_cnt    <= '0;
            r_ldac_n <= 1'b0;
            r_state  <= LDAC;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        LDAC: begin
          if (r_cnt == LDAC_M1) begin
            r_cnt    <= '0;
            r_ldac_n <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign ds_cs_n_o    = r_cs_n;
  assign ds_sck_o     = r_sck;
  assign ds_sdi_o     = r_sdi;
  assign ds_ldac_n_o  = r_ldac_n;
  assign ds_busy_o    = r_busy;
  assign ds_done_o    = r_done;
  assign ds_ovr_cnt_o = r_ovr;

endmodule

// File: tb/tb_dac_spi_driver.sv
module tb_dac_spi_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, start;
  logic [11:0] s1, s2;
  logic        cs_n, sck, sdi, ldac_n, busy, done;
  logic [7:0]  ovr;

  logic        en1, start1;
  logic        cs_n1, sck1, sdi1, ldac_n1, busy1, done1;
  logic [7:0]  ovr1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_spi_driver #(.CLK_DIV(4), .CFG_BITS(3'b011)) u_dut (
    .sys_clk_i(clk), .sys_rst_i(rst_n), .ds_en_i(en), .ds_start_i(start),
    .ds_sample_1_i(s1), .ds_sample_2_i(s2),
    .ds_cs_n_o(cs_n), .ds_sck_o(sck), .ds_sdi_o(sdi), .ds_ldac_n_o(ldac_n),
    .ds_busy_o(busy), .ds_done_o(done), .ds_ovr_cnt_o(ovr)
  );

  dac_spi_driver #(.CLK_DIV(1), .CFG_BITS(3'b011)) u_dut1 (
    .sys_clk_i(clk), .sys_rst_i(rst_n), .ds_en_i(en1), .ds_start_i(start1),
    .ds_sample_1_i(12'h5A5), .ds_sample_2_i(12'hA5A),
    .ds_cs_n_o(cs_n1), .ds_sck_o(sck1), .ds_sdi_o(sdi1), .ds_ldac_n_o(ldac_n1),
    .ds_busy_o(busy1), .ds_done_o(done1), .ds_ovr_cnt_o(ovr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // SPI frame monitor for the CLK_DIV=4 instance: shifts SDI on each SCK rise,
  // stores the frame when CS releases, and flags SCK/SDI activity with CS high.
  logic [15:0] m_sh = '0;
  logic [15:0] m_frame [2];
  int          m_nbits [2];
  int          m_bits = 0;
  int          m_nf = 0;
  int          m_viol = 0;
  logic        m_prev_sck = 1'b0;
  logic        m_prev_cs = 1'b1;

  always @(negedge clk) begin
    if (!cs_n && sck && !m_prev_sck) begin
      m_sh = {m_sh[14:0], sdi};
      m_bits++;
    end
    if (cs_n && !m_prev_cs) begin
      if (m_nf < 2) begin
        m_frame[m_nf] = m_sh;
        m_nbits[m_nf] = m_bits;
      end
      m_nf++;
      m_sh = '0;
      m_bits = 0;
    end
    if (cs_n && (sck || sdi)) m_viol++;
    m_prev_sck = sck;
    m_prev_cs  = cs_n;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, 32'(cs_n), 32'd1);
    chk({tag, "_sck"}, 32'(sck), 32'd0);
    chk({tag, "_sdi"}, 32'(sdi), 32'd0);
    chk({tag, "_ldac_n"}, 32'(ldac_n), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ovr"}, 32'(ovr), 32'd0);
  endtask

  // One full CLK_DIV=4 transfer. Extra starts at cycles p1/p2 or every cycle
  // 1..pall_hi; en drops from cycle en_drop on. Samples are scrambled after t0.
  task automatic run4(input string tag, input logic [11:0] a, input logic [11:0] b,
                      input int p1, input int p2, input int pall_hi, input int en_drop,
                      input logic [15:0] exp_a, input logic [15:0] exp_b);
    int cs_first = -1, cs_rise = -1, cs_cnt = 0;
    int busy_first = -1, busy_cnt = 0;
    int done_k = -1, done_cnt = 0;
    int ldac_first = -1, ldac_cnt = 0;
    m_nf = 0;
    m_viol = 0;
    m_bits = 0;
    m_sh = '0;
    @(negedge clk);
    en = 1'b1; start = 1'b1; s1 = a; s2 = b;
    for (int k = 1; k <= 280; k++) begin
      @(negedge clk);
      if (!cs_n) begin
        cs_cnt++;
        if (cs_first < 0) cs_first = k;
      end else if (cs_first >= 0 && cs_rise < 0) begin
        cs_rise = k;
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (!ldac_n) begin
        ldac_cnt++;
        if (ldac_first < 0) ldac_first = k;
      end
      start = (k == p1) || (k == p2) || (k <= pall_hi);
      en    = (k < en_drop);
      if (k == 1) begin
        s1 = ~a;
        s2 = ~b;
      end
    end
    start = 1'b0;
    en = 1'b1;
    chk({tag, "_cs_first"}, 32'(cs_first), 32'd1);
    chk({tag, "_cs_rise"}, 32'(cs_rise), 32'd129);
    chk({tag, "_cs_cnt"}, 32'(cs_cnt), 32'd256);
    chk({tag, "_busy_first"}, 32'(busy_first), 32'd1);
    chk({tag, "_busy_cnt"}, 32'(busy_cnt), 32'd272);
    chk({tag, "_done_k"}, 32'(done_k), 32'd273);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_ldac_first"}, 32'(ldac_first), 32'd265);
    chk({tag, "_ldac_cnt"}, 32'(ldac_cnt), 32'd8);
    chk({tag, "_nframes"}, 32'(m_nf), 32'd2);
    chk({tag, "_frame_a"}, 32'(m_frame[0]), 32'(exp_a));
    chk({tag, "_frame_b"}, 32'(m_frame[1]), 32'(exp_b));
    chk({tag, "_bits_a"}, 32'(m_nbits[0]), 32'd16);
    chk({tag, "_bits_b"}, 32'(m_nbits[1]), 32'd16);
    chk({tag, "_idle_viol"}, 32'(m_viol), 32'd0);
    $display("transfer %s: frames %h %h ovr=%0d", tag, m_frame[0], m_frame[1], ovr);
  endtask

  initial begin
    int cs_seen, busy_seen;
    int d_cnt, d_bad, b_cnt, c_cnt, v_cnt;

    rst_n = 1'b0; en = 1'b0; start = 1'b0; s1 = '0; s2 = '0;
    en1 = 1'b0; start1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    $display("reset: cs_n=%0b sck=%0b busy=%0b ovr=%0d", cs_n, sck, busy, ovr);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run4("basic", 12'hABC, 12'h000, -1, -1, 0, 1000, 16'h3ABC, 16'hB000);
    chk("basic_ovr", 32'(ovr), 32'd0);

    run4("ovr2", 12'h123, 12'hFFF, 10, 200, 0, 1000, 16'h3123, 16'hBFFF);
    chk("ovr2_cnt", 32'(ovr), 32'd2);

    run4("sat1", 12'h555, 12'hAAA, -1, -1, 272, 1000, 16'h3555, 16'hBAAA);
    chk("sat1_cnt", 32'(ovr), 32'd255);
    run4("sat2", 12'h001, 12'h800, -1, -1, 272, 1000, 16'h3001, 16'hB800);
    chk("sat2_cnt", 32'(ovr), 32'd255);

    // Start with enable low: nothing happens, counter untouched.
    cs_seen = 0; busy_seen = 0;
    @(negedge clk);
    en = 1'b0; start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (!cs_n) cs_seen++;
      if (busy) busy_seen++;
    end
    en = 1'b1;
    chk("en0_cs", 32'(cs_seen), 32'd0);
    chk("en0_busy", 32'(busy_seen), 32'd0);
    chk("en0_ovr", 32'(ovr), 32'd255);
    $display("en0 start: cs_low=%0d busy=%0d ovr=%0d", cs_seen, busy_seen, ovr);

    // Reset in the middle of frame A.
    @(negedge clk);
    en = 1'b1; start = 1'b1; s1 = 12'hFED; s2 = 12'h321;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk("mid_cs_low", 32'(cs_n), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    $display("mid-frame reset: cs_n=%0b busy=%0b ovr=%0d", cs_n, busy, ovr);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run4("postrst", 12'hFED, 12'h321, -1, -1, 0, 1000, 16'h3FED, 16'hB321);
    chk("postrst_ovr", 32'(ovr), 32'd0);

    // Enable dropped mid-transfer: transfer still completes.
    run4("endrop", 12'h0F0, 12'hF0F, -1, -1, 0, 20, 16'h30F0, 16'hBF0F);
    chk("endrop_ovr", 32'(ovr), 32'd0);

    // CLK_DIV=1: restart in every DONE cycle, one start every 69 cycles.
    d_cnt = 0; d_bad = 0; b_cnt = 0; c_cnt = 0; v_cnt = 0;
    @(negedge clk);
    en1 = 1'b1; start1 = 1'b1;
    for (int k = 1; k <= 350; k++) begin
      @(negedge clk);
      if (done1) begin
        d_cnt++;
        if ((k % 69) != 0) d_bad++;
      end
      if (busy1) b_cnt++;
      if (!cs_n1) c_cnt++;
      if (cs_n1 && (sck1 || sdi1)) v_cnt++;
      start1 = ((k % 69) == 0) && (k <= 276);
    end
    start1 = 1'b0;
    chk("div1_done_cnt", 32'(d_cnt), 32'd5);
    chk("div1_done_pos", 32'(d_bad), 32'd0);
    chk("div1_busy_cnt", 32'(b_cnt), 32'd340);
    chk("div1_cs_cnt", 32'(c_cnt), 32'd320);
    chk("div1_idle_viol", 32'(v_cnt), 32'd0);
    chk("div1_ovr", 32'(ovr1), 32'd0);
    $display("div1 back-to-back: done=%0d busy_cycles=%0d ovr=%0d", d_cnt, b_cnt, ovr1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dac_spi_driver.md
DAC_SPI_DRIVER -- requirements
Module: dac_spi_driver

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the number of sys_clk_i cycles per SCK half-period; legal range is 1..255.
REQ-002 Parameter CFG_BITS, default 3'b011, SHALL supply {BUF, GA_n, SHDN_n}, placed in frame bits [14:12].
REQ-003 sys_clk_i  input  1  SHALL be the system clock; all logic is clocked on its rising edge.
REQ-004 sys_rst_i  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 ds_en_i  input  1  SHALL be the transfer enable; starts are accepted only while it is high.
REQ-006 ds_start_i  input  1  SHALL request a transfer when pulsed for one cycle (sample-rate tick).
REQ-007 ds_sample_1_i  input  12  SHALL carry the channel A sample (sine output 1), unsigned.
REQ-008 ds_sample_2_i  input  12  SHALL carry the channel B sample (sine output 2), unsigned.
REQ-009 ds_cs_n_o  output  1  SHALL be the DAC chip select, active-low.
REQ-010 ds_sck_o  output  1  SHALL be the serial clock, SPI mode 0 (idles low).
REQ-011 ds_sdi_o  output  1  SHALL be the serial data, MSB first.
REQ-012 ds_ldac_n_o  output  1  SHALL be the DAC latch strobe, active-low.
REQ-013 ds_busy_o  output  1  SHALL be high while a transfer is in progress.
REQ-014 ds_done_o  output  1  SHALL pulse for one cycle when a transfer completes.
REQ-015 ds_ovr_cnt_o  output  8  SHALL count dropped starts and saturate at 255.

Function
REQ-016 Frame layout SHALL be 16 bits: [15] channel (A=0, B=1); [14:12] CFG_BITS; [11:0] sample.
REQ-017 The FSM SHALL have states IDLE, SHIFT_A, GAP_A, SHIFT_B, GAP_B, LDAC, DONE.
REQ-018 In IDLE, ds_start_i=1 with ds_en_i=1 at cycle t0 SHALL latch both samples and enter SHIFT_A at t0+1.
REQ-019 Samples SHALL be latched only at t0; input changes after t0 SHALL NOT affect the transfer.
REQ-020 In SHIFT_x: ds_cs_n_o=0 from the first cycle, with ds_sdi_o = bit 15 of the frame.
REQ-021 SCK rising edge SHALL occur CLK_DIV cycles after each data change; the falling edge follows CLK_DIV cycles later, and SDI advances one bit on that same cycle.
REQ-022 After the 16th falling edge (32*CLK_DIV cycles in SHIFT_x), ds_cs_n_o SHALL rise on that cycle and the FSM SHALL enter GAP_x.
REQ-023 GAP_x SHALL last CLK_DIV cycles; GAP_A leads to SHIFT_B and GAP_B leads to LDAC.
REQ-024 LDAC SHALL hold ds_ldac_n_o=0 for 2*CLK_DIV cycles, then enter DONE.
REQ-025 DONE SHALL last one cycle: ds_done_o=1, ds_busy_o=0, then return to IDLE.
REQ-026 ds_busy_o SHALL be high from t0+1 for exactly 68*CLK_DIV cycles.
REQ-027 A start in DONE is accepted, i.e. back-to-back transfers have a 1-cycle minimum gap.
REQ-028 ds_start_i=1 while busy (any state except IDLE/DONE) SHALL be ignored and SHALL increment ds_ovr_cnt_o, saturating at 255 with no wrap.
REQ-029 ds_start_i=1 with ds_en_i=0 SHALL be ignored with no count.
REQ-030 ds_en_i falling mid-transfer SHALL NOT abort the transfer; the current transfer completes.
REQ-031 ds_sck_o SHALL be low whenever ds_cs_n_o=1.
REQ-032 ds_sdi_o SHALL be 0 outside SHIFT states.
REQ-033 All outputs SHALL be driven directly from registers (glitch-free).

Reset
REQ-034 Reset assertion SHALL take effect immediately, at any state, including mid-frame.
REQ-035 Reset values SHALL be: FSM=IDLE, ds_cs_n_o=1, ds_sck_o=0, ds_sdi_o=0, ds_ldac_n_o=1, ds_busy_o=0, ds_done_o=0, ds_ovr_cnt_o=0, latched samples=0.
REQ-036 After reset release, the first start SHALL be accepted on the first clock edge.

Verification
REQ-037 CLK_DIV=4, sample_1=12'hABC, start at t0 -> frame A 16'h3ABC MSB-first on 16 SCK rising edges; CS low t0+1..t0+128; LDAC low 8 cycles; done at t0+273.
REQ-038 Sample_2=12'h000 and 12'hFFF -> frame B 16'hB000 and 16'hBFFF respectively; SCK low while CS high.
REQ-039 Start pulses at t0+10 and t0+200 during busy -> ds_ovr_cnt_o=2; transfer timing unchanged; 300 extra busy starts -> counter holds 255.
REQ-040 Reset asserted at t0+50 mid-SHIFT_A -> all outputs at reset values immediately; next start yields a full, correct transfer.
REQ-041 CLK_DIV=1, starts repeated every 69 cycles -> every start accepted, done every 69 cycles, ovr_cnt=0.
REQ-042 ds_en_i=0 with a start pulse -> no CS activity, busy stays 0, ovr_cnt unchanged; en dropped mid-transfer -> transfer completes normally.
